// File: rtl/nes_move_decoder.sv
// ---------------------------------------------------------------------------
// nes_move_decoder
//
// Purpose:
//   Turns the per-frame NES controller snapshot into held button levels,
//   per-frame press edges and one-cycle fighter move strobes. The moves are
//   punch, kick, jump, pause and the quarter-circle fireball combo
//   (down, down+forward, forward, then A).
//
// Configuration:
//   NES_MOVE_DEBOUNCE_EN - when defined, a held bit only changes after the
//   masked raw bit has shown the same new value in two consecutive frames.
//   This costs one extra frame of latency.
//
// Parameters:
//   WINDOW        max frames allowed between successive combo steps
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   btn_valid     one-cycle strobe, btn carries a fresh controller frame
//   btn[7:0]      raw {right,left,down,up,select,start,b,a}, 1 = pressed
//   facing_right  orientation sampled with btn_valid (forward = right if 1)
//   held[7:0]     filtered button levels, same bit order as btn
//   pressed[7:0]  rising edges of held for the latest frame
//   move_valid    one-cycle strobe when the latest frame produced a move
//   move[2:0]     0 NONE, 1 PUNCH, 2 KICK, 3 JUMP, 4 FIREBALL, 5 PAUSE
//   combo_state   combo FSM state: 0 IDLE, 1 S_DOWN, 2 S_DIAG, 3 S_FWD
// ---------------------------------------------------------------------------
module nes_move_decoder #(
    parameter int WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_valid,
    input  logic [7:0] btn,
    input  logic       facing_right,
    output logic [7:0] held,
    output logic [7:0] pressed,
    output logic       move_valid,
    output logic [2:0] move,
    output logic [1:0] combo_state
);

    localparam int CW = $clog2(WINDOW + 1);

    localparam logic [2:0] MOVE_NONE     = 3'd0;
    localparam logic [2:0] MOVE_PUNCH    = 3'd1;
    localparam logic [2:0] MOVE_KICK     = 3'd2;
    localparam logic [2:0] MOVE_JUMP     = 3'd3;
    localparam logic [2:0] MOVE_FIREBALL = 3'd4;
    localparam logic [2:0] MOVE_PAUSE    = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_DOWN = 2'd1,
        S_DIAG = 2'd2,
        S_FWD  = 2'd3
    } combo_t;

    combo_t          state_q, state_d, next_state;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      held_q, held_d;
    logic [7:0]      pressed_q, pressed_d;
    logic            move_valid_q, move_valid_d;
    logic [2:0]      move_q, move_d;

    logic [7:0]      masked;
    logic [7:0]      held_new;
    logic [7:0]      pressed_new;
    logic            fwd;
    logic            down;
    logic            timeout;
    logic            fireball;
    logic            restart;
    logic [CW-1:0]   cnt_next;
    logic [2:0]      move_new;

`ifdef NES_MOVE_DEBOUNCE_EN
    logic [7:0]      hist_q, hist_d;
    logic [7:0]      agree;
`endif

    // Frame evaluation: everything below is computed from the incoming frame
    // every cycle, but only committed to the registers when btn_valid is high.
    always_comb begin
        // Opposite directions cancel each other out before anything else sees them.
        masked = btn;
        if (btn[7] && btn[6]) begin
            masked[7:6] = 2'b00;
        end
        if (btn[5] && btn[4]) begin
            masked[5:4] = 2'b00;
        end

`ifdef NES_MOVE_DEBOUNCE_EN
        // A bit moves to the new value only when this frame agrees with the last one.
        agree    = ~(masked ^ hist_q);
        held_new = (agree & masked) | (~agree & held_q);
        hist_d   = hist_q;
`else
        held_new = masked;
`endif

        pressed_new = held_new & ~held_q;
        fwd         = facing_right ? held_new[7] : held_new[6];
        down        = held_new[5];

        // A combo that has sat WINDOW frames without advancing dies here, and
        // that kill takes precedence over any step attempted in the same frame.
        timeout    = (state_q != IDLE) && (cnt_q == CW'(WINDOW));
        fireball   = 1'b0;
        restart    = 1'b0;
        next_state = state_q;

        if (timeout) begin
            next_state = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (down && !fwd) next_state = S_DOWN;
                end
                S_DOWN: begin
                    if (down && fwd)        next_state = S_DIAG;
                    else if (!down && !fwd) next_state = IDLE;
                end
                S_DIAG: begin
                    if (fwd && !down) next_state = S_FWD;
                    else if (!fwd)    next_state = IDLE;
                end
                S_FWD: begin
                    if (pressed_new[0]) begin
                        fireball   = 1'b1;
                        next_state = IDLE;
                    end else if (!fwd || down) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end

        // A fresh down press (not toward the opponent) always starts a new attempt.
        if (pressed_new[5] && !fwd) begin
            next_state = S_DOWN;
            restart    = 1'b1;
        end

        // Window counter restarts on any state change or restart, and counts
        // frames spent waiting in a non-idle state.
        if ((next_state != state_q) || restart) begin
            cnt_next = '0;
        end else if (state_q != IDLE) begin
            cnt_next = (cnt_q == CW'(WINDOW)) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_next = '0;
        end

        if (fireball)             move_new = MOVE_FIREBALL;
        else if (pressed_new[0])  move_new = MOVE_PUNCH;
        else if (pressed_new[1])  move_new = MOVE_KICK;
        else if (pressed_new[4])  move_new = MOVE_JUMP;
        else if (pressed_new[2])  move_new = MOVE_PAUSE;
        else                      move_new = MOVE_NONE;

        state_d      = state_q;
        cnt_d        = cnt_q;
        held_d       = held_q;
        pressed_d    = pressed_q;
        move_d       = move_q;
        move_valid_d = 1'b0;

        if (btn_valid) begin
            state_d      = next_state;
            cnt_d        = cnt_next;
            held_d       = held_new;
            pressed_d    = pressed_new;
            move_d       = move_new;
            move_valid_d = (move_new != MOVE_NONE);
`ifdef NES_MOVE_DEBOUNCE_EN
            hist_d       = masked;
`endif
        end
    end

    // State registers; reset wins over a coincident frame, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            held_q       <= '0;
            pressed_q    <= '0;
            move_q       <= MOVE_NONE;
            move_valid_q <= 1'b0;
`ifdef NES_MOVE_DEBOUNCE_EN
            hist_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            held_q       <= held_d;
            pressed_q    <= pressed_d;
            move_q       <= move_d;
            move_valid_q <= move_valid_d;
`ifdef NES_MOVE_DEBOUNCE_EN
            hist_q       <= hist_d;
`endif
        end
    end

    assign held        = held_q;
    assign pressed     = pressed_q;
    assign move_valid  = move_valid_q;
    assign move        = move_q;
    assign combo_state = state_q;

endmodule
